// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported unified memory between the fetch (read-only) and memory
// stage (read/write) requesters, one fixed-latency transaction at a time.
module unified_mem_arbiter #(
   parameter int unsigned LATENCY = 2,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic              IF_Req,
   input  logic [ADDR_W-1:0] IF_Addr,
   output logic              IF_Valid,
   output logic [DATA_W-1:0] IF_RData,
   input  logic              MEM_Req,
   input  logic              MEM_Write,
   input  logic [1:0]        MEM_Width,
   input  logic [ADDR_W-1:0] MEM_Addr,
   input  logic [DATA_W-1:0] MEM_WData,
   output logic              MEM_Valid,
   output logic [DATA_W-1:0] MEM_RData,
   output logic              Mem_En,
   output logic              Mem_WE,
   output logic [1:0]        Mem_Width,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic [DATA_W-1:0] Mem_WData,
   input  logic [DATA_W-1:0] Mem_RData,
   output logic              Stall_Fetch,
   output logic              Stall_Mem
);

   localparam int unsigned CNT_W = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic             last_mem;
   logic             own_mem;
   logic             own_wr;
   logic             grant_c;
   logic             pick_mem_c;
   logic             lat_done_c;

   // Round-robin: on a tie the requester that did not win last time is chosen
   always_comb begin
      state_nx   = state;
      grant_c    = 1'b0;
      pick_mem_c = MEM_Req & (~IF_Req | ~last_mem);
      lat_done_c = (cnt == CNT_W'(LATENCY));
      case (state)
         IDLE: begin
            if (IF_Req | MEM_Req) begin
               grant_c  = 1'b1;
               state_nx = ISSUE;
            end
         end
         ISSUE:   state_nx = WAIT;
         WAIT:    if (lat_done_c) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         cnt       <= '0;
         last_mem  <= 1'b0;
         own_mem   <= 1'b0;
         own_wr    <= 1'b0;
         IF_Valid  <= 1'b0;
         IF_RData  <= '0;
         MEM_Valid <= 1'b0;
         MEM_RData <= '0;
         Mem_En    <= 1'b0;
         Mem_WE    <= 1'b0;
         Mem_Width <= 2'b00;
         Mem_Addr  <= '0;
         Mem_WData <= '0;
      end else begin
         Mem_En    <= 1'b0;
         Mem_WE    <= 1'b0;
         IF_Valid  <= 1'b0;
         MEM_Valid <= 1'b0;
         if (grant_c) begin
            own_mem   <= pick_mem_c;
            last_mem  <= pick_mem_c;
            own_wr    <= pick_mem_c & MEM_Write;
            Mem_En    <= 1'b1;
            Mem_WE    <= pick_mem_c & MEM_Write;
            Mem_Width <= pick_mem_c ? MEM_Width : 2'b00;
            Mem_Addr  <= pick_mem_c ? MEM_Addr : (IF_Addr & ~ADDR_W'(3));
            Mem_WData <= pick_mem_c ? MEM_WData : '0;
         end
         if (state == ISSUE) cnt <= CNT_W'(1);
         // Memory data is valid in the cycle the counter reaches LATENCY
         if (state == WAIT) begin
            if (lat_done_c) begin
               if (own_mem) begin
                  MEM_Valid <= 1'b1;
                  MEM_RData <= own_wr ? '0 : Mem_RData;
               end else begin
                  IF_Valid  <= 1'b1;
                  IF_RData  <= Mem_RData;
               end
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

   assign Stall_Fetch = IF_Req & ~IF_Valid;
   assign Stall_Mem   = MEM_Req & ~MEM_Valid;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: cycle-indexed transaction model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_unified_mem_arbiter;

   localparam int L = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, mem_req, mem_write;
   logic [31:0] if_addr, mem_addr, mem_wdata, mem_rdata_in;
   logic [1:0]  mem_width;
   logic        if_valid, mem_valid, mem_en, mem_we, stall_f, stall_m;
   logic [31:0] if_rdata, mem_rdata, m_addr, m_wdata;
   logic [1:0]  m_width;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   unified_mem_arbiter #(.LATENCY(L), .ADDR_W(32), .DATA_W(32)) dut (
      .Clock(clk), .Reset_n(rst_n),
      .IF_Req(if_req), .IF_Addr(if_addr), .IF_Valid(if_valid), .IF_RData(if_rdata),
      .MEM_Req(mem_req), .MEM_Write(mem_write), .MEM_Width(mem_width),
      .MEM_Addr(mem_addr), .MEM_WData(mem_wdata), .MEM_Valid(mem_valid),
      .MEM_RData(mem_rdata), .Mem_En(mem_en), .Mem_WE(mem_we), .Mem_Width(m_width),
      .Mem_Addr(m_addr), .Mem_WData(m_wdata), .Mem_RData(mem_rdata_in),
      .Stall_Fetch(stall_f), .Stall_Mem(stall_m)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      if (a == 32'h40) return 32'h2008_0005;
      return {a[15:0], 16'hC0DE} ^ 32'h1234_0000;
   endfunction

   // Memory device: returns data exactly L cycles after a strobe, garbage otherwise
   int          resp_cyc = -1;
   logic [31:0] resp_addr;
   always @(negedge clk) if (mem_en === 1'b1) begin
      resp_cyc  = cyc + L;
      resp_addr = m_addr;
   end
   always @(posedge clk) begin
      #1;
      if (cyc == resp_cyc) mem_rdata_in = mem_fn(resp_addr);
      else                 mem_rdata_in = 32'hBAD0_0000 ^ 32'(cyc);
   end

   // Model: each grant at cycle k strobes at k+1, samples at k+1+L, answers at k+2+L,
   // and the arbiter is free again at k+3+L.
   bit          armed = 0, rst_prev = 0, last_mem = 0;
   bit          o_mem, o_wr;
   int          free_cyc = 0, issue_cyc = -1, valid_cyc = -1;
   logic [31:0] o_addr, o_wdata, cap;
   logic [1:0]  o_width;

   always @(negedge clk) begin
      bit e_en, e_ifv, e_memv;
      int k;
      k = cyc;
      if (armed) begin
         e_en   = (k == issue_cyc);
         e_ifv  = (k == valid_cyc) && !o_mem;
         e_memv = (k == valid_cyc) && o_mem;
         chk("mem_en", mem_en, e_en);
         chk("mem_we", mem_we, e_en && o_wr);
         chk("if_valid", if_valid, e_ifv);
         chk("mem_valid", mem_valid, e_memv);
         chk("stall_fetch", stall_f, if_req && !e_ifv);
         chk("stall_mem", stall_m, mem_req && !e_memv);
         if (e_en) begin
            chk("mem_addr", m_addr, o_addr);
            chk("mem_width", m_width, o_width);
            if (o_wr) chk("mem_wdata", m_wdata, o_wdata);
         end
         if (e_ifv)  chk("if_rdata", if_rdata, cap);
         if (e_memv) chk("mem_rdata", mem_rdata, o_wr ? 32'h0 : cap);
         if (rst_prev) begin
            chk("rst_if_rdata", if_rdata, 0);
            chk("rst_mem_rdata", mem_rdata, 0);
            chk("rst_mem_addr", m_addr, 0);
            chk("rst_mem_wdata", m_wdata, 0);
            chk("rst_mem_width", m_width, 0);
         end
      end
      rst_prev = !rst_n;
      if (!rst_n) begin
         armed = 1; free_cyc = k + 1; issue_cyc = -1; valid_cyc = -1; last_mem = 0;
      end else if (armed) begin
         if (issue_cyc >= 0 && k == issue_cyc + L) cap = mem_rdata_in;
         if (k >= free_cyc && (if_req || mem_req)) begin
            o_mem    = mem_req && (!if_req || !last_mem);
            last_mem = o_mem;
            o_wr     = o_mem && mem_write;
            o_addr   = o_mem ? mem_addr : {if_addr[31:2], 2'b00};
            o_width  = o_mem ? mem_width : 2'b00;
            o_wdata  = mem_wdata;
            issue_cyc = k + 1;
            valid_cyc = k + 2 + L;
            free_cyc  = k + 3 + L;
         end
      end
   end

   // Window recorder for the literal checks (index 0 = first cycle of the window)
   logic        ob_en[0:19], ob_we[0:19], ob_ifv[0:19], ob_memv[0:19], ob_sf[0:19], ob_sm[0:19];
   logic [31:0] ob_addr[0:19], ob_ifd[0:19], ob_memd[0:19];
   logic [31:0] en_q[$];

   task automatic observe(input int len);
      en_q.delete();
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         ob_en[i] = mem_en;     ob_we[i] = mem_we;     ob_addr[i] = m_addr;
         ob_ifv[i] = if_valid;  ob_ifd[i] = if_rdata;
         ob_memv[i] = mem_valid; ob_memd[i] = mem_rdata;
         ob_sf[i] = stall_f;    ob_sm[i] = stall_m;
         if (mem_en === 1'b1) en_q.push_back(m_addr);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 0; if_req = 1; if_addr = 32'h10; mem_req = 1; mem_write = 0;
      mem_width = 2'b00; mem_addr = 32'h300; mem_wdata = 32'h0; mem_rdata_in = 32'h0;
      // 1: reset with both requests high, then MEM wins the first tie
      tick();
      tick();
      @(negedge clk);
      chk("t1_rst_en", mem_en, 0);
      chk("t1_rst_ifv", if_valid, 0);
      chk("t1_rst_memv", mem_valid, 0);
      tick(); rst_n = 1;
      observe(5);
      chk("t1_en", ob_en[1], 1);
      chk("t1_first_mem", ob_addr[1], 32'h300);
      chk("t1_memv", ob_memv[4], 1);
      tick(); mem_req = 0;
      observe(5);
      chk("t1_if_addr", ob_addr[1], 32'h10);
      chk("t1_ifv", ob_ifv[4], 1);
      tick(); if_req = 0;
      tick(); tick();

      // 2: single fetch with unaligned address
      tick(); if_req = 1; if_addr = 32'h42;
      observe(5);
      chk("t2_en", ob_en[1], 1);
      chk("t2_addr", ob_addr[1], 32'h40);
      chk("t2_ifv", ob_ifv[4], 1);
      chk("t2_ifd", ob_ifd[4], 32'h2008_0005);
      for (int i = 0; i < 4; i++) chk("t2_stall_hi", ob_sf[i], 1);
      chk("t2_stall_lo", ob_sf[4], 0);
      tick(); if_req = 0;
      tick(); tick();

      // 3: simultaneous MEM write and IF read
      tick(); if_req = 1; if_addr = 32'h80;
      mem_req = 1; mem_write = 1; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF;
      observe(5);
      chk("t3_we", ob_we[1], 1);
      chk("t3_waddr", ob_addr[1], 32'h100);
      chk("t3_memv", ob_memv[4], 1);
      chk("t3_memd", ob_memd[4], 32'h0);
      tick(); mem_req = 0; mem_write = 0;
      observe(5);
      chk("t3_if_en", ob_en[1], 1);
      chk("t3_if_addr", ob_addr[1], 32'h80);
      chk("t3_ifv", ob_ifv[4], 1);
      tick(); if_req = 0;
      tick(); tick();

      // 4: both held for four transactions -> alternating grants
      tick(); if_req = 1; if_addr = 32'h44; mem_req = 1; mem_addr = 32'h200;
      observe(20);
      chk("t4_count", en_q.size(), 4);
      for (int i = 0; i < 4; i++)
         chk("t4_order", (i < en_q.size()) ? en_q[i] : 32'hFFFF_FFFF,
             (i % 2 == 0) ? 32'h200 : 32'h44);
      tick(); if_req = 0; mem_req = 0;
      tick(); tick();

      // 5: reset in the middle of a fetch
      tick(); if_req = 1; if_addr = 32'h48;
      observe(2);
      chk("t5_en", ob_en[1], 1);
      tick(); rst_n = 0;
      observe(1);
      tick(); rst_n = 1;
      observe(5);
      chk("t5_no_stale_valid", ob_ifv[1], 0);
      chk("t5_fresh_en", ob_en[1], 1);
      chk("t5_ifv", ob_ifv[4], 1);
      chk("t5_ifd", ob_ifd[4], mem_fn(32'h48));
      tick(); if_req = 0;
      tick(); tick();

      // 6: MEM read whose request is dropped mid-transaction
      tick(); mem_req = 1; mem_write = 0; mem_width = 2'b10; mem_addr = 32'h200;
      observe(2);
      tick(); mem_req = 0;
      observe(3);
      chk("t6_stall", ob_sm[0], 0);
      chk("t6_memv", ob_memv[2], 1);
      chk("t6_memd", ob_memd[2], mem_fn(32'h200));
      tick(); if_req = 1; if_addr = 32'h4C;
      observe(2);
      chk("t6_next_en", ob_en[1], 1);
      chk("t6_next_addr", ob_addr[1], 32'h4C);
      tick(); if_req = 0;
      repeat (6) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
